// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types and the
// byte-strobe merge helper used by the register file.
package axi_lite_pkg;

    localparam int RESP_W = 3;
    localparam logic [RESP_W-1:0] RESP_OKAY   = 3'd0;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 3'd2;

    // Widest data bus the merge helper supports; callers zero-extend and truncate.
    localparam int MAX_DW = 1024;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [MAX_DW-1:0] apply_strb(input logic [MAX_DW-1:0] old_word,
                                                     input logic [MAX_DW-1:0] data,
                                                     input logic [MAX_SW-1:0] strb);
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_SW; b++)
            if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_REGS byte-strobed registers at BASE_ADDR + 4*i,
// independent write/read FSMs with registered handshakes, SLVERR on bad decode.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-2:0] NREG   = (ADDR_WIDTH-1)'(NUM_REGS);
    localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    w_state_t                            w_state;
    r_state_t                            r_state;
    logic [ADDR_WIDTH-1:0]               aw_q;
    logic [DATA_WIDTH-1:0]               wdata_q;
    logic [STRB_W-1:0]                   wstrb_q;

    logic                                aw_hs, w_hs, commit, c_ok, r_ok;
    logic [ADDR_WIDTH-1:0]               c_addr;
    logic [DATA_WIDTH-1:0]               c_data;
    logic [STRB_W-1:0]                   c_strb;
    logic [IDX_W-1:0]                    c_idx, r_idx;

    // Borrow bit of the widened subtraction flags addr < BASE.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return !off[ADDR_WIDTH] && (off[1:0] == 2'b00) && ({1'b0, off[ADDR_WIDTH-1:2]} < NREG);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE;
        return off[IDX_W+1:2];
    endfunction

    assign regs_o = regs;

    // Commit merges whichever half was latched with whichever half is live.
    always_comb begin
        aw_hs  = s_axi_awvalid && s_axi_awready;
        w_hs   = s_axi_wvalid && s_axi_wready;
        c_addr = (w_state == W_WAIT_DATA) ? aw_q    : s_axi_awaddr;
        c_data = (w_state == W_WAIT_ADDR) ? wdata_q : s_axi_wdata;
        c_strb = (w_state == W_WAIT_ADDR) ? wstrb_q : s_axi_wstrb;
        commit = 1'b0;
        case (w_state)
            W_IDLE:      commit = aw_hs && w_hs;
            W_WAIT_DATA: commit = w_hs;
            W_WAIT_ADDR: commit = aw_hs;
            default:     commit = 1'b0;
        endcase
        c_ok  = addr_ok(c_addr);
        c_idx = addr_idx(c_addr);
        r_ok  = addr_ok(s_axi_araddr);
        r_idx = addr_idx(s_axi_araddr);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= '0;
            regs          <= '0;
            aw_q          <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else if (commit) begin
            if (c_ok)
                regs[c_idx] <= DATA_WIDTH'(apply_strb(MAX_DW'(regs[c_idx]), MAX_DW'(c_data),
                                                      MAX_SW'(c_strb)));
            s_axi_bresp   <= c_ok ? OKAY : SLVERR;
            s_axi_bvalid  <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            w_state       <= W_RESP;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_q          <= s_axi_awaddr;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_WAIT_DATA;
                    end else if (w_hs) begin
                        wdata_q       <= s_axi_wdata;
                        wstrb_q       <= s_axi_wstrb;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b0;
                        w_state       <= W_WAIT_ADDR;
                    end else begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rdata   <= r_ok ? regs[r_idx] : '0;
                        s_axi_rresp   <= r_ok ? OKAY : SLVERR;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_RESP;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: behavioural transaction model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a BASE_ADDR=16 copy.
module tb_axi_lite_regfile;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] awaddr = '0, araddr = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [2:0] bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] regs;

    logic [7:0] c_awaddr = '0, c_araddr = '0;
    logic c_awvalid = 0, c_wvalid = 0, c_bready = 0, c_arvalid = 0, c_rready = 0;
    logic [31:0] c_wdata = '0;
    logic [3:0] c_wstrb = '0;
    logic c_awready, c_wready, c_bvalid, c_arready, c_rvalid;
    logic [2:0] c_bresp, c_rresp;
    logic [31:0] c_rdata;
    logic [127:0] c_regs;

    axi_lite_regfile dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs)
    );

    axi_lite_regfile #(.BASE_ADDR(16)) dut16 (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(c_awaddr), .s_axi_awvalid(c_awvalid), .s_axi_awready(c_awready),
        .s_axi_wdata(c_wdata), .s_axi_wstrb(c_wstrb), .s_axi_wvalid(c_wvalid), .s_axi_wready(c_wready),
        .s_axi_bresp(c_bresp), .s_axi_bvalid(c_bvalid), .s_axi_bready(c_bready),
        .s_axi_araddr(c_araddr), .s_axi_arvalid(c_arvalid), .s_axi_arready(c_arready),
        .s_axi_rdata(c_rdata), .s_axi_rresp(c_rresp), .s_axi_rvalid(c_rvalid), .s_axi_rready(c_rready),
        .regs_o(c_regs)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a write lands once both its address and data are in.
    logic [31:0] m_regs [4];
    bit m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    bit aw_have, w_have, l_aw, l_w, l_ar;
    logic [2:0] m_bresp, m_rresp;
    logic [31:0] m_rdata, wd_q;
    logic [3:0] ws_q;
    int aw_q;

    function automatic bit m_ok(input int a);
        return (a % 4 == 0) && (a / 4 < 4);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        aw_have = 0; w_have = 0; l_aw = 0; l_w = 0; l_ar = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
    endtask

    task automatic tick();
        bit b_hs, r_hs;
        @(posedge clk);
        if (!rst_n) m_reset();
        else begin
            l_aw = awvalid && m_awready;
            l_w  = wvalid && m_wready;
            l_ar = arvalid && m_arready;
            b_hs = m_bvalid && bready;
            r_hs = m_rvalid && rready;
            if (r_hs) m_rvalid = 0;
            if (l_ar) begin
                m_rdata  = m_ok(araddr) ? m_regs[araddr / 4] : 32'h0;
                m_rresp  = m_ok(araddr) ? 3'd0 : 3'd2;
                m_rvalid = 1;
            end
            if (b_hs) m_bvalid = 0;
            if (l_aw) begin aw_have = 1; aw_q = awaddr; end
            if (l_w) begin w_have = 1; wd_q = wdata; ws_q = wstrb; end
            if (aw_have && w_have) begin
                if (m_ok(aw_q))
                    for (int b = 0; b < 4; b++)
                        if (ws_q[b]) m_regs[aw_q / 4][8*b +: 8] = wd_q[8*b +: 8];
                m_bresp = m_ok(aw_q) ? 3'd0 : 3'd2;
                m_bvalid = 1;
                aw_have = 0; w_have = 0;
            end
            m_awready = !aw_have && !m_bvalid;
            m_wready  = !w_have && !m_bvalid;
            m_arready = !m_rvalid;
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [127:0] flat;
        for (int i = 0; i < 4; i++) flat[i*32 +: 32] = m_regs[i];
        chk("regs_o", regs, flat);
        chk("awready", awready, m_awready);
        chk("wready", wready, m_wready);
        chk("arready", arready, m_arready);
        chk("bvalid", bvalid, m_bvalid);
        chk("rvalid", rvalid, m_rvalid);
        if (m_bvalid) chk("bresp", bresp, m_bresp);
        if (m_rvalid) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, m_rresp);
        end
    end

    initial begin
        m_reset();
        repeat (3) tick();
        rst_n = 1;
        chk("rst_awready", awready, 0);
        chk("rst_rdata", rdata, 0);
        tick();
        chk("idle_awready", awready, 1);
        chk("idle_wready", wready, 1);

        // Same-cycle write then read back.
        awvalid = 1; awaddr = 8'h04; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, 0);
        chk("wr_reg1", regs[63:32], 32'hDEADBEEF);
        bready = 1; tick(); bready = 0;
        arvalid = 1; araddr = 8'h04; tick(); arvalid = 0;
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_rresp", rresp, 0);
        rready = 1; tick(); rready = 0;

        // Data ahead of address, partial strobe.
        wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5; tick(); wvalid = 0;
        tick();
        chk("early_w_reg0", regs[31:0], 0);
        awvalid = 1; awaddr = 8'h00; tick(); awvalid = 0;
        chk("strb_reg0", regs[31:0], 32'h00220044);
        chk("strb_bvalid", bvalid, 1);
        bready = 1; tick(); bready = 0;

        // Decode errors.
        awvalid = 1; awaddr = 8'h02; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        tick(); awvalid = 0; wvalid = 0;
        chk("err_bresp", bresp, 2);
        chk("err_regs", regs, {64'h0, 32'hDEADBEEF, 32'h00220044});
        bready = 1; tick(); bready = 0;
        arvalid = 1; araddr = 8'h10; tick(); arvalid = 0;
        chk("err_rresp", rresp, 2);
        chk("err_rdata", rdata, 0);
        rready = 1; tick(); rready = 0;

        // Backpressure on both response channels.
        awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick(); awvalid = 0; wvalid = 0;
        repeat (5) begin
            tick();
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, 0);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
        end
        bready = 1; tick(); bready = 0;
        arvalid = 1; araddr = 8'h08; tick(); arvalid = 0;
        repeat (5) begin
            tick();
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'hCAFEF00D);
        end
        rready = 1; tick(); rready = 0;

        // Reset while a write response is pending.
        awvalid = 1; awaddr = 8'h0C; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
        tick(); awvalid = 0; wvalid = 0;
        chk("pre_rst_bvalid", bvalid, 1);
        #2 rst_n = 0; m_reset();
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_regs", regs, 0);
        tick();
        rst_n = 1;
        chk("rel_awready", awready, 0);
        tick();
        chk("rel_awready1", awready, 1);
        chk("rel_wready1", wready, 1);

        // Random traffic, including misaligned and out-of-range addresses.
        for (int n = 0; n < 3000; n++) begin
            if (!(awvalid && !l_aw)) begin
                awvalid = 1'($urandom_range(0, 1)); awaddr = 8'($urandom_range(0, 19));
            end
            if (!(wvalid && !l_w)) begin
                wvalid = 1'($urandom_range(0, 1)); wdata = $urandom; wstrb = 4'($urandom);
            end
            if (!(arvalid && !l_ar)) begin
                arvalid = 1'($urandom_range(0, 1)); araddr = 8'($urandom_range(0, 19));
            end
            bready = ($urandom_range(0, 9) < 7);
            rready = ($urandom_range(0, 9) < 7);
            tick();
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        repeat (3) tick();

        // Instance at BASE_ADDR=16.
        c_awvalid = 1; c_awaddr = 8'd20; c_wvalid = 1; c_wdata = 32'hA5; c_wstrb = 4'hF;
        tick(); c_awvalid = 0; c_wvalid = 0;
        chk("b16_bvalid", c_bvalid, 1);
        chk("b16_bresp", c_bresp, 0);
        chk("b16_reg1", c_regs[63:32], 32'hA5);
        c_bready = 1; tick(); c_bready = 0;
        c_arvalid = 1; c_araddr = 8'd24; tick(); c_arvalid = 0;
        chk("b16_rd24_rvalid", c_rvalid, 1);
        chk("b16_rd24_rdata", c_rdata, 0);
        chk("b16_rd24_rresp", c_rresp, 0);
        c_rready = 1; tick(); c_rready = 0;
        c_arvalid = 1; c_araddr = 8'd20; tick(); c_arvalid = 0;
        chk("b16_rd20_rdata", c_rdata, 32'hA5);
        c_rready = 1; tick(); c_rready = 0;
        c_arvalid = 1; c_araddr = 8'd8; tick(); c_arvalid = 0;
        chk("b16_rd8_rresp", c_rresp, 2);
        chk("b16_rd8_rdata", c_rdata, 0);
        c_rready = 1; tick(); c_rready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
